writeback_regfile: RTL

Architected-state sink at the far end of the writeback path. Accepts the registered writeback bundle (functional unit code, two enable/address/value lanes), commits it to the 32-entry GPR file, the condition register and XER, and tracks in-flight destinations for dispatch through a busy scoreboard. Serves two registered read ports with same-cycle writeback bypass to the operand-fetch stage.

---
 rtl/writeback_regfile.sv | 205 ++++++++++++++++++++
 1 files changed

// File: rtl/writeback_regfile.sv
// writeback_regfile
// Architected-state sink for the writeback path. It commits the two-lane
// writeback bundle to the GPR file, the condition register and XER. It keeps
// a busy scoreboard of in-flight destinations for dispatch, and it serves two
// registered operand read ports that bypass a same-cycle GPR commit.
//
// Bit numbering of CR, XER and the writeback value follows the architecture's
// MSB-first convention: architected bit 0 is the most significant bit. So CR
// field 0 is condReg_o[31:28], XER SO/OV/CA (bits 32/33/34) are XER_o[31:30:29],
// and value bit 0 is reg2WritebackVal_i[63].
module writeback_regfile #(
  parameter int addressSize  = 64,
  parameter int regWidth     = 5,
  parameter int numRegs      = 2**regWidth,
  parameter int FXUnitCode   = 0,
  parameter int LdStUnitCode = 2
) (
  input  logic                   clock_i,
  input  logic                   reset_i,
  input  logic [2:0]             functionalUnitCode_i,
  input  logic                   reg1WritebackEnable_i,
  input  logic                   reg2WritebackEnable_i,
  input  logic [regWidth-1:0]    reg1WritebackAddress_i,
  input  logic [regWidth-1:0]    reg2WritebackAddress_i,
  input  logic [addressSize-1:0] reg1WritebackVal_i,
  input  logic [addressSize-1:0] reg2WritebackVal_i,
  input  logic                   reserveEnable_i,
  input  logic [regWidth-1:0]    reserveAddress_i,
  input  logic                   readEnable_i,
  input  logic [regWidth-1:0]    readAddress1_i,
  input  logic [regWidth-1:0]    readAddress2_i,
  output logic [addressSize-1:0] readVal1_o,
  output logic [addressSize-1:0] readVal2_o,
  output logic                   readPending1_o,
  output logic                   readPending2_o,
  output logic                   readValid_o,
  output logic [31:0]            condReg_o,
  output logic [addressSize-1:0] XER_o,
  output logic [numRegs-1:0]     busyVector_o
);

  // XER flag positions in LSB-0 numbering (architected bits 32, 33, 34)
  localparam int XerSoBit = addressSize - 1 - 32;
  localparam int XerOvBit = addressSize - 1 - 33;
  localparam int XerCaBit = addressSize - 1 - 34;
  // Value bits 0/1/2 carry SO/OV/CA for an FX condition update
  localparam int ValSoBit = addressSize - 1;
  localparam int ValOvBit = addressSize - 2;
  localparam int ValCaBit = addressSize - 3;

  logic [addressSize-1:0] gpr_r [numRegs];
  logic [31:0]            cr_r;
  logic [addressSize-1:0] xer_r;
  logic [numRegs-1:0]     busy_r;
  logic [addressSize-1:0] rd_val1_r;
  logic [addressSize-1:0] rd_val2_r;
  logic                   rd_pend1_r;
  logic                   rd_pend2_r;
  logic                   rd_valid_r;

  logic                   unit_ls_s;
  logic                   unit_fx_s;
  logic                   wr1_en_s;
  logic                   wr2_en_s;
  logic                   cond_upd_s;
  logic [numRegs-1:0]     wr1_hot_s;
  logic [numRegs-1:0]     wr2_hot_s;
  logic [numRegs-1:0]     clear_s;
  logic [numRegs-1:0]     reserve_hot_s;
  logic [numRegs-1:0]     busy_next_s;
  logic [addressSize-1:0] byp1_s;
  logic [addressSize-1:0] byp2_s;
  logic                   pend1_s;
  logic                   pend2_s;
  logic [31:0]            cr_next_s;
  logic [addressSize-1:0] xer_next_s;

  // Decode the unit code into GPR write lanes and the CR/XER update lane
  always_comb begin
    unit_ls_s  = (functionalUnitCode_i == 3'(LdStUnitCode));
    unit_fx_s  = (functionalUnitCode_i == 3'(FXUnitCode));
    wr1_en_s   = reg1WritebackEnable_i & (unit_ls_s | unit_fx_s);
    wr2_en_s   = reg2WritebackEnable_i & unit_ls_s;
    cond_upd_s = reg2WritebackEnable_i & unit_fx_s;
    if (wr1_en_s) begin
      wr1_hot_s = numRegs'(1) << reg1WritebackAddress_i;
    end else begin
      wr1_hot_s = '0;
    end
    if (wr2_en_s) begin
      wr2_hot_s = numRegs'(1) << reg2WritebackAddress_i;
    end else begin
      wr2_hot_s = '0;
    end
    if (reserveEnable_i) begin
      reserve_hot_s = numRegs'(1) << reserveAddress_i;
    end else begin
      reserve_hot_s = '0;
    end
    clear_s     = wr1_hot_s | wr2_hot_s;
    // A reserve in the same cycle as a clear of that register leaves it busy
    busy_next_s = (busy_r & ~clear_s) | reserve_hot_s;
  end

  // Operand selection with same-cycle writeback bypass, lane1 has priority
  always_comb begin
    if (wr1_en_s && (reg1WritebackAddress_i == readAddress1_i)) begin
      byp1_s = reg1WritebackVal_i;
    end else if (wr2_en_s && (reg2WritebackAddress_i == readAddress1_i)) begin
      byp1_s = reg2WritebackVal_i;
    end else begin
      byp1_s = gpr_r[readAddress1_i];
    end
    if (wr1_en_s && (reg1WritebackAddress_i == readAddress2_i)) begin
      byp2_s = reg1WritebackVal_i;
    end else if (wr2_en_s && (reg2WritebackAddress_i == readAddress2_i)) begin
      byp2_s = reg2WritebackVal_i;
    end else begin
      byp2_s = gpr_r[readAddress2_i];
    end
    // Pending sees this cycle's clears but not this cycle's reserve
    pend1_s = busy_r[readAddress1_i] & ~clear_s[readAddress1_i];
    pend2_s = busy_r[readAddress2_i] & ~clear_s[readAddress2_i];
  end

  // Next CR/XER for an FX condition update; SO is sticky
  always_comb begin
    cr_next_s  = cr_r;
    xer_next_s = xer_r;
    if (cond_upd_s) begin
      for (int f = 0; f < 8; f++) begin
        if (reg2WritebackAddress_i[2:0] == 3'(f)) begin
          cr_next_s[31-4*f -: 4] = reg2WritebackVal_i[3:0];
        end else begin
          cr_next_s[31-4*f -: 4] = cr_r[31-4*f -: 4];
        end
      end
      xer_next_s[XerOvBit] = reg2WritebackVal_i[ValOvBit];
      xer_next_s[XerCaBit] = reg2WritebackVal_i[ValCaBit];
      xer_next_s[XerSoBit] = xer_r[XerSoBit] | reg2WritebackVal_i[ValSoBit];
    end else begin
      cr_next_s  = cr_r;
      xer_next_s = xer_r;
    end
  end

  // GPR file commit; lane1 wins when both lanes target one register
  always_ff @(posedge clock_i or negedge reset_i) begin
    if (!reset_i) begin
      for (int i = 0; i < numRegs; i++) begin
        gpr_r[i] <= '0;
      end
    end else begin
      for (int i = 0; i < numRegs; i++) begin
        if (wr1_hot_s[i]) begin
          gpr_r[i] <= reg1WritebackVal_i;
        end else if (wr2_hot_s[i]) begin
          gpr_r[i] <= reg2WritebackVal_i;
        end
      end
    end
  end

  // Condition register, XER and busy scoreboard state
  always_ff @(posedge clock_i or negedge reset_i) begin
    if (!reset_i) begin
      cr_r   <= 32'h0000_0000;
      xer_r  <= '0;
      busy_r <= '0;
    end else begin
      cr_r   <= cr_next_s;
      xer_r  <= xer_next_s;
      busy_r <= busy_next_s;
    end
  end

  // Registered read ports; data and pending hold while no read is requested
  always_ff @(posedge clock_i or negedge reset_i) begin
    if (!reset_i) begin
      rd_val1_r  <= '0;
      rd_val2_r  <= '0;
      rd_pend1_r <= 1'b0;
      rd_pend2_r <= 1'b0;
      rd_valid_r <= 1'b0;
    end else if (readEnable_i) begin
      rd_val1_r  <= byp1_s;
      rd_val2_r  <= byp2_s;
      rd_pend1_r <= pend1_s;
      rd_pend2_r <= pend2_s;
      rd_valid_r <= 1'b1;
    end else begin
      rd_valid_r <= 1'b0;
    end
  end

  assign readVal1_o     = rd_val1_r;
  assign readVal2_o     = rd_val2_r;
  assign readPending1_o = rd_pend1_r;
  assign readPending2_o = rd_pend2_r;
  assign readValid_o    = rd_valid_r;
  assign condReg_o      = cr_r;
  assign XER_o          = xer_r;
  assign busyVector_o   = busy_r;

endmodule
